// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 register-write controller.
package spi_pkg;

    localparam int SPI_FRAME_W = 16;
    localparam int SPI_ADDR_W  = 7;
    localparam int SPI_DATA_W  = 8;

    localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_ctrl_state_t;

    function automatic logic [SPI_FRAME_W-1:0] pack_frame(
        input logic                  rw,
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] data
    );
        return {rw, addr, data};
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Register-command valid/ready port of the SPI controller.
interface spi_controller_if;
    import spi_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rw;
    logic [SPI_ADDR_W-1:0] cmd_addr;
    logic [SPI_DATA_W-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_rw, output cmd_addr, output cmd_data,
                    input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_rw, input  cmd_addr, input  cmd_data,
                    output cmd_ready);

endinterface

// File: rtl/spi_ctrl_cmd_fifo.sv
// Synchronous command FIFO holding packed 16-bit frames; used when SPI_CTRL_FIFO_EN is defined.
module spi_ctrl_cmd_fifo
    import spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [SPI_FRAME_W-1:0] wdata,
    input  logic                   pop,
    output logic [SPI_FRAME_W-1:0] rdata,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [SPI_FRAME_W-1:0] mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]            rd_ptr_q, rd_ptr_d;
    logic                   do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller: serialises {rw, addr, data} commands as 16-bit frames on SCLK/nCS/COPI.
// Optional command FIFO in front of the FSM is enabled by defining SPI_CTRL_FIFO_EN.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_IDLE    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.slave  cmd,
    output logic             busy,
    output logic             frame_done,
    output logic             SCLK,
    output logic             nCS,
    output logic             COPI
);

    localparam int CNT_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE) + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
    localparam logic [4:0]       BITS       = 5'(SPI_FRAME_W);

    if (CLK_DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("spi_controller: illegal CLK_DIV or FIFO_DEPTH");
    end

    spi_ctrl_state_t        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [SPI_FRAME_W-1:0] shreg_q, shreg_d;
    logic                   sclk_q, sclk_d;
    logic                   ncs_q, ncs_d;
    logic                   copi_q, copi_d;
    logic                   frame_done_q, frame_done_d;

    logic                   start;
    logic [SPI_FRAME_W-1:0] start_frame;

`ifdef SPI_CTRL_FIFO_EN
    logic                   fifo_full, fifo_empty;
    logic [SPI_FRAME_W-1:0] fifo_rdata;

    spi_ctrl_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd.cmd_valid && cmd.cmd_ready),
        .wdata (pack_frame(cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_data)),
        .pop   (start),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd.cmd_ready = !fifo_full && !rst;
    assign start         = (state_q == ST_IDLE) && !fifo_empty;
    assign start_frame   = fifo_rdata;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
`else
    // Ready only in IDLE, so a held cmd_valid cannot shorten the inter-frame gap.
    assign cmd.cmd_ready = (state_q == ST_IDLE) && !rst;
    assign start         = cmd.cmd_valid && cmd.cmd_ready;
    assign start_frame   = pack_frame(cmd.cmd_rw, cmd.cmd_addr, cmd.cmd_data);
    assign busy          = (state_q != ST_IDLE);
`endif

    assign SCLK       = sclk_q;
    assign nCS        = ncs_q;
    assign COPI       = copi_q;
    assign frame_done = frame_done_q;

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        sclk_d       = sclk_q;
        ncs_d        = ncs_q;
        copi_d       = copi_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d   = start_frame;
                    copi_d    = start_frame[SPI_FRAME_W-1];
                    ncs_d     = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d  = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else if (bit_cnt_q < BITS) begin
                        shreg_d = shreg_q << 1;
                        copi_d  = shreg_d[SPI_FRAME_W-1];
                    end else begin
                        copi_d  = 1'b0;
                        state_d = ST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d        = '0;
                    ncs_d        = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            sclk_q       <= 1'b0;
            ncs_q        <= 1'b1;
            copi_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            sclk_q       <= sclk_d;
            ncs_q        <= ncs_d;
            copi_q       <= copi_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
